// File: rtl/serial_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : serial_fifo_bridge
// Description : Byte FIFOs between a host and a simple serial core. The TX
//               FIFO feeds a launcher that pulses start_trasmit once per byte
//               and waits for the core to go busy and then idle again. The RX
//               FIFO captures bytes from the core and flags lost bytes with a
//               sticky overrun bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_fifo_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // host TX side
  input  logic                  tx_wr,
  input  logic [7:0]            tx_wdata,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  // host RX side
  input  logic                  rx_rd,
  output logic [7:0]            rx_rdata,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  rx_overrun,
  input  logic                  ovr_clr,
  // serial core side
  output logic                  start_trasmit,
  output logic [7:0]            tx_data,
  input  logic                  transmitint,
  input  logic                  reciveint,
  input  logic [7:0]            rx_data
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   C_DEPTH   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_IDLE = 2'd2
  } state_e;

  state_e                  state_q, state_d;

  // TX FIFO storage and bookkeeping
  logic [7:0]              tx_mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   tx_wptr_q, tx_rptr_q;
  logic [DEPTH_LOG2:0]     tx_count_q, tx_count_d;
  logic                    tx_push, tx_pop;
  logic                    start_q;
  logic [7:0]              tx_data_q;

  // RX FIFO storage and bookkeeping
  logic [7:0]              rx_mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   rx_wptr_q, rx_rptr_q;
  logic [DEPTH_LOG2:0]     rx_count_q, rx_count_d;
  logic                    rx_push, rx_pop, rx_full;
  logic                    ovr_q, ovr_d;

  // Status flags are pure decodes of the registered counts
  assign tx_full       = (tx_count_q == C_DEPTH);
  assign tx_count      = tx_count_q;
  assign rx_full       = (rx_count_q == C_DEPTH);
  assign rx_empty      = (rx_count_q == '0);
  assign rx_count      = rx_count_q;
  assign rx_rdata      = rx_mem_q[rx_rptr_q];
  assign rx_overrun    = ovr_q;
  assign start_trasmit = start_q;
  assign tx_data       = tx_data_q;

  // A full TX FIFO still accepts a write when the launcher pops in the same cycle
  assign tx_push = tx_wr && (!tx_full || tx_pop);
  // Empty-read is dropped; a full RX FIFO accepts a byte only alongside a pop
  assign rx_pop  = rx_rd && !rx_empty;
  assign rx_push = reciveint && (!rx_full || rx_pop);

  // Launcher next state: pop one byte when idle, then track the core busy/idle handshake
  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (transmitint && (tx_count_q != '0)) begin
          tx_pop  = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (!transmitint) state_d = WAIT_IDLE;
      WAIT_IDLE: if (transmitint)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Occupancy and sticky-overrun next values
  always_comb begin
    tx_count_d = tx_count_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + C_CNT_ONE;
      2'b01:   tx_count_d = tx_count_q - C_CNT_ONE;
      default: tx_count_d = tx_count_q;
    endcase

    rx_count_d = rx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + C_CNT_ONE;
      2'b01:   rx_count_d = rx_count_q - C_CNT_ONE;
      default: rx_count_d = rx_count_q;
    endcase

    // a lost byte wins over a simultaneous clear so the event is never missed
    ovr_d = ovr_q;
    if (reciveint && rx_full && !rx_rd) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  // TX pointers, launcher state, launch pulse and held output byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
      start_q    <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      tx_count_q <= tx_count_d;
      start_q    <= tx_pop;
      if (tx_pop) begin
        tx_data_q <= tx_mem_q[tx_rptr_q];
        tx_rptr_q <= tx_rptr_q + C_PTR_ONE;
      end
      if (tx_push) begin
        tx_wptr_q <= tx_wptr_q + C_PTR_ONE;
      end
    end
  end

  // RX pointers, occupancy and overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      ovr_q      <= 1'b0;
    end else begin
      rx_count_q <= rx_count_d;
      ovr_q      <= ovr_d;
      if (rx_pop) begin
        rx_rptr_q <= rx_rptr_q + C_PTR_ONE;
      end
      if (rx_push) begin
        rx_wptr_q <= rx_wptr_q + C_PTR_ONE;
      end
    end
  end

  // Storage arrays are not reset; writes are suppressed during reset
  always_ff @(posedge clk) begin
    if (!rst && tx_push) begin
      tx_mem_q[tx_wptr_q] <= tx_wdata;
    end
    if (!rst && rx_push) begin
      rx_mem_q[rx_wptr_q] <= rx_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_fifo_bridge
// Description : Self-checking bench for serial_fifo_bridge. A queue-based
//               model is compared against the outputs every cycle; directed
//               sequences add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_fifo_bridge;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_wr;
  logic [7:0]    tx_wdata;
  logic          tx_full;
  logic [DL:0]   tx_count;
  logic          rx_rd;
  logic [7:0]    rx_rdata;
  logic          rx_empty;
  logic [DL:0]   rx_count;
  logic          rx_overrun;
  logic          ovr_clr;
  logic          start_trasmit;
  logic [7:0]    tx_data;
  logic          transmitint;
  logic          reciveint;
  logic [7:0]    rx_data;

  serial_fifo_bridge #(.DEPTH_LOG2(DL)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_wr        (tx_wr),
    .tx_wdata     (tx_wdata),
    .tx_full      (tx_full),
    .tx_count     (tx_count),
    .rx_rd        (rx_rd),
    .rx_rdata     (rx_rdata),
    .rx_empty     (rx_empty),
    .rx_count     (rx_count),
    .rx_overrun   (rx_overrun),
    .ovr_clr      (ovr_clr),
    .start_trasmit(start_trasmit),
    .tx_data      (tx_data),
    .transmitint  (transmitint),
    .reciveint    (reciveint),
    .rx_data      (rx_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // TX side: a queue plus "launched, waiting for core busy" / "waiting for
  // core idle" flags; RX side: a queue plus the sticky flag.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [7:0] pulses[$];
  bit         m_valid     = 1'b0;
  bit         m_wait_low  = 1'b0;
  bit         m_wait_high = 1'b0;
  bit         m_start     = 1'b0;
  bit         m_ovr       = 1'b0;
  bit         m_launch    = 1'b0;
  bit         m_lost      = 1'b0;
  logic [7:0] m_txd       = 8'h00;

  // Compare outputs against the model, then advance the model with the
  // inputs that the next rising edge will sample.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_tx_count",   32'(tx_count),   32'(m_tx.size()));
      chk("m_tx_full",    32'(tx_full),    32'(m_tx.size() == DEPTH));
      chk("m_rx_count",   32'(rx_count),   32'(m_rx.size()));
      chk("m_rx_empty",   32'(rx_empty),   32'(m_rx.size() == 0));
      chk("m_rx_overrun", 32'(rx_overrun), 32'(m_ovr));
      chk("m_start",      32'(start_trasmit), 32'(m_start));
      chk("m_tx_data",    32'(tx_data),    32'(m_txd));
      if (m_rx.size() > 0) chk("m_rx_rdata", 32'(rx_rdata), 32'(m_rx[0]));
      if (start_trasmit === 1'b1) pulses.push_back(tx_data);
    end
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      m_wait_low  = 1'b0;
      m_wait_high = 1'b0;
      m_start     = 1'b0;
      m_ovr       = 1'b0;
      m_txd       = 8'h00;
      m_valid     = 1'b1;
    end else begin
      m_launch = !m_wait_low && !m_wait_high && transmitint && (m_tx.size() > 0);
      if (m_wait_low && !transmitint) begin
        m_wait_low  = 1'b0;
        m_wait_high = 1'b1;
      end else if (m_wait_high && transmitint) begin
        m_wait_high = 1'b0;
      end
      m_start = m_launch;
      if (m_launch) begin
        m_txd      = m_tx.pop_front();
        m_wait_low = 1'b1;
      end
      if (tx_wr && m_tx.size() < DEPTH) m_tx.push_back(tx_wdata);
      if (rx_rd && m_rx.size() > 0) void'(m_rx.pop_front());
      m_lost = 1'b0;
      if (reciveint) begin
        if (m_rx.size() < DEPTH) m_rx.push_back(rx_data);
        else m_lost = 1'b1;
      end
      if (m_lost) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
    end
  end

  // ---------------------------------------------------------------- stimulus
  int busy    = 0;
  bit core_en = 1'b0;

  // One clock; inputs change 1 time unit after the edge. When enabled, a
  // simple core model goes busy for three cycles after each launch pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    if (core_en) begin
      if (busy > 0) begin
        busy--;
        if (busy == 0) transmitint = 1'b1;
      end else if (start_trasmit) begin
        transmitint = 1'b0;
        busy        = 3;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pulse_at(input int k);
    return (pulses.size() > k) ? 32'(pulses[k]) : 32'hDEAD_BEEF;
  endfunction

  initial begin
    rst = 1'b1; tx_wr = 1'b0; tx_wdata = 8'h00; rx_rd = 1'b0; ovr_clr = 1'b0;
    transmitint = 1'b0; reciveint = 1'b0; rx_data = 8'h00;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_tx_count", 32'(tx_count), 0);
    chk("rst_tx_full",  32'(tx_full), 0);
    chk("rst_rx_count", 32'(rx_count), 0);
    chk("rst_rx_empty", 32'(rx_empty), 1);
    chk("rst_overrun",  32'(rx_overrun), 0);
    chk("rst_start",    32'(start_trasmit), 0);
    chk("rst_tx_data",  32'(tx_data), 0);

    // three bytes through a core that goes busy then idle
    transmitint = 1'b1; core_en = 1'b1; pulses.delete();
    tx_wr = 1'b1; tx_wdata = 8'h55; tick();
    chk("lat_start_e1", 32'(start_trasmit), 0);
    chk("lat_count_e1", 32'(tx_count), 1);
    tx_wdata = 8'hA3; tick();
    chk("lat_start_e2", 32'(start_trasmit), 1);
    chk("lat_txd_e2",   32'(tx_data), 32'h55);
    tx_wdata = 8'h0F; tick();
    tx_wr = 1'b0;
    chk("lat_start_e3", 32'(start_trasmit), 0);
    chk("lat_count_e3", 32'(tx_count), 2);
    for (int i = 0; i < 100 && pulses.size() < 3; i++) tick();
    repeat (10) tick();
    chk("tx_pulse_count", 32'(pulses.size()), 3);
    chk("tx_pulse0", pulse_at(0), 32'h55);
    chk("tx_pulse1", pulse_at(1), 32'hA3);
    chk("tx_pulse2", pulse_at(2), 32'h0F);
    chk("tx_drained", 32'(tx_count), 0);
    core_en = 1'b0;

    // fill TX with core busy: 17th write dropped, nothing launched
    do_reset();
    transmitint = 1'b0; pulses.delete();
    for (int i = 0; i < 17; i++) begin
      tx_wr = 1'b1; tx_wdata = 8'(i); tick();
      chk("tx_full_step", 32'(tx_full), 32'(i >= 15));
    end
    tx_wr = 1'b0;
    repeat (3) tick();
    chk("tx_full_count", 32'(tx_count), 16);
    chk("tx_full_flag",  32'(tx_full), 1);
    chk("tx_no_launch",  32'(pulses.size()), 0);

    // write while full coincides with a launch: accepted, count unchanged
    transmitint = 1'b1; tx_wr = 1'b1; tx_wdata = 8'hAB; tick();
    tx_wr = 1'b0;
    chk("full_wr_pop_count", 32'(tx_count), 16);
    chk("full_wr_pop_start", 32'(start_trasmit), 1);
    chk("full_wr_pop_data",  32'(tx_data), 32'h00);

    // reset while waiting for the core to go busy, five bytes queued
    do_reset();
    transmitint = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tx_wr = 1'b1; tx_wdata = 8'(8'h61 + i); tick();
    end
    tx_wr = 1'b0;
    transmitint = 1'b1; tick();
    chk("busy_count", 32'(tx_count), 5);
    chk("busy_start", 32'(start_trasmit), 1);
    chk("busy_data",  32'(tx_data), 32'h61);
    rst = 1'b1; tx_wr = 1'b1; tx_wdata = 8'h99; tick();
    rst = 1'b0; tx_wr = 1'b0;
    chk("midrst_count", 32'(tx_count), 0);
    chk("midrst_start", 32'(start_trasmit), 0);
    chk("midrst_data",  32'(tx_data), 0);
    tx_wr = 1'b1; tx_wdata = 8'h3C; tick();
    tx_wr = 1'b0;
    chk("postrst_start_e1", 32'(start_trasmit), 0);
    tick();
    chk("postrst_start_e2", 32'(start_trasmit), 1);
    chk("postrst_txd",      32'(tx_data), 32'h3C);

    // RX: reset masks a receive, empty read ignored
    rst = 1'b1; reciveint = 1'b1; rx_data = 8'h42; tick();
    rst = 1'b0; reciveint = 1'b0;
    chk("rx_rst_ignore", 32'(rx_count), 0);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    chk("rx_empty_rd", 32'(rx_count), 0);

    // RX overflow: 16 bytes kept, 17th lost
    for (int i = 0; i < 16; i++) begin
      reciveint = 1'b1; rx_data = 8'(i); tick();
      reciveint = 1'b0; tick();
    end
    reciveint = 1'b1; rx_data = 8'hEE; tick();
    reciveint = 1'b0;
    chk("rx_ovf_count", 32'(rx_count), 16);
    chk("rx_ovf_flag",  32'(rx_overrun), 1);
    for (int i = 0; i < 16; i++) begin
      chk("rx_ovf_data", 32'(rx_rdata), 32'(i));
      rx_rd = 1'b1; tick();
    end
    rx_rd = 1'b0;
    chk("rx_ovf_empty",  32'(rx_empty), 1);
    chk("rx_ovf_sticky", 32'(rx_overrun), 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("rx_ovf_clr", 32'(rx_overrun), 0);

    // overrun event and clear together: set wins; clear alone then clears
    for (int i = 0; i < 16; i++) begin
      reciveint = 1'b1; rx_data = 8'(8'h20 + i); tick();
    end
    reciveint = 1'b1; rx_data = 8'hBB; ovr_clr = 1'b1; tick();
    reciveint = 1'b0; ovr_clr = 1'b0;
    chk("setclr_flag",  32'(rx_overrun), 1);
    chk("setclr_count", 32'(rx_count), 16);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("clr_alone", 32'(rx_overrun), 0);

    // full RX, receive and read in the same cycle
    reciveint = 1'b1; rx_data = 8'h77; rx_rd = 1'b1; tick();
    reciveint = 1'b0; rx_rd = 1'b0;
    chk("rdwr_count", 32'(rx_count), 16);
    chk("rdwr_ovr",   32'(rx_overrun), 0);
    for (int i = 0; i < 16; i++) begin
      chk("rdwr_data", 32'(rx_rdata), (i < 15) ? 32'(8'h21 + i) : 32'h77);
      rx_rd = 1'b1; tick();
    end
    rx_rd = 1'b0;
    chk("rdwr_empty", 32'(rx_empty), 1);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
